// File: rtl/universal_sr_ctrl_if.sv
// Command/handshake bundle between a bus master and the shift-register sequencer.
// The master drives cmd_*; the controller (slave) drives sel/parin/busy/done/cmd_ready.
interface universal_sr_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic [1:0]       sel;
  logic [WIDTH-1:0] parin;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid,
    output cmd_load,
    output cmd_dir,
    output cmd_count,
    output cmd_data,
    input  cmd_ready,
    input  sel,
    input  parin,
    input  busy,
    input  done
  );

  modport slave (
    input  cmd_valid,
    input  cmd_load,
    input  cmd_dir,
    input  cmd_count,
    input  cmd_data,
    output cmd_ready,
    output sel,
    output parin,
    output busy,
    output done
  );

endinterface

// File: rtl/universal_sr_ctrl.sv
// Command sequencer for a 4-bit universal shift register. Accepts one command at a time
// (optional parallel load, then N shifts in one direction) and pulses done at the end.
// Every output comes straight from a flop; next-state output values are decoded from the
// next FSM state so the registered outputs line up with the state they describe.
module universal_sr_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input logic              clk,
  input logic              clr,
  universal_sr_ctrl_if.slave bus
);

  localparam logic [1:0] SelHold  = 2'b00;
  localparam logic [1:0] SelRight = 2'b01;
  localparam logic [1:0] SelLeft  = 2'b10;
  localparam logic [1:0] SelLoad  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] parin_q, parin_d;
  logic [1:0]       sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             accept;

  // ready_q is high exactly in IDLE, so it doubles as the accept qualifier.
  assign accept = bus.cmd_valid & ready_q;

  // Next-state logic: command capture, load/shift/done sequencing and shift counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    parin_d = parin_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          parin_d = bus.cmd_data;
          dir_d   = bus.cmd_dir;
          cnt_d   = bus.cmd_count;
          if (bus.cmd_load) begin
            state_d = StLoad;
          end else if (bus.cmd_count != '0) begin
            state_d = StShift;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLoad: begin
        state_d = (cnt_q != '0) ? StShift : StDone;
      end
      StShift: begin
        // Only entered with a nonzero count, so this never underflows.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the upcoming state, so the flops present it during that state.
  always_comb begin
    sel_d   = SelHold;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    ready_d = 1'b0;
    unique case (state_d)
      StIdle: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      StLoad: begin
        sel_d = SelLoad;
      end
      StShift: begin
        sel_d = dir_d ? SelLeft : SelRight;
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: begin
        sel_d = SelHold;
      end
    endcase
  end

  // State and output registers; clr aborts any command with no done pulse.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      parin_q <= '0;
      sel_q   <= SelHold;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      parin_q <= parin_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.sel       = sel_q;
  assign bus.parin     = parin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cmd_ready = ready_q;

  // Structural invariants of the sequencer.
  sel_load_only_in_load : assert property (@(posedge clk) disable iff (!clr)
    (sel_q == SelLoad) |-> (state_q == StLoad));

  shift_cnt_nonzero : assert property (@(posedge clk) disable iff (!clr)
    (state_q == StShift) |-> (cnt_q != '0));

  done_single_cycle : assert property (@(posedge clk) disable iff (!clr)
    done_q |=> !done_q);

  ready_only_idle : assert property (@(posedge clk) disable iff (!clr)
    ready_q |-> (state_q == StIdle) && (sel_q == SelHold));

endmodule

// File: tb/tb_universal_sr_ctrl.sv
// Bench for universal_sr_ctrl: a per-command expected-cycle queue model checked every
// cycle, a behavioural shift register fed by the DUT, and directed literal checks.
module tb_universal_sr_ctrl;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned CNT_W = 4;

  // Expected per-cycle outputs packed as {sel, busy, done, cmd_ready}.
  localparam logic [4:0] IdleV = 5'b00_0_0_1;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  universal_sr_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  universal_sr_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [4:0]       exp_q[$];
  logic [4:0]       cur = IdleV;
  logic [WIDTH-1:0] m_parin = '0;
  logic [WIDTH-1:0] sr_q = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: on each accepted command, queue the full expected output schedule.
  initial begin
    forever begin
      @(posedge clk or negedge clr);
      if (!clr) begin
        exp_q.delete();
        cur     = IdleV;
        m_parin = '0;
      end else begin
        // Downstream shift register driven by the DUT's (pre-edge) outputs.
        case (bus.sel)
          2'b01:   sr_q = {1'b0, sr_q[WIDTH-1:1]};
          2'b10:   sr_q = {sr_q[WIDTH-2:0], 1'b0};
          2'b11:   sr_q = bus.parin;
          default: sr_q = sr_q;
        endcase
        if (exp_q.size() != 0) begin
          cur = exp_q.pop_front();
        end else if (cur == IdleV && bus.cmd_valid === 1'b1) begin
          m_parin = bus.cmd_data;
          if (bus.cmd_load) exp_q.push_back(5'b11_1_0_0);
          for (int i = 0; i < int'(bus.cmd_count); i++) begin
            exp_q.push_back(bus.cmd_dir ? 5'b10_1_0_0 : 5'b01_1_0_0);
          end
          exp_q.push_back(5'b00_1_1_0);
          cur = exp_q.pop_front();
        end else begin
          cur = IdleV;
        end
      end
    end
  end

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("m_sel", 32'(bus.sel), 32'(cur[4:3]));
        check("m_busy", 32'(bus.busy), 32'(cur[2]));
        check("m_done", 32'(bus.done), 32'(cur[1]));
        check("m_ready", 32'(bus.cmd_ready), 32'(cur[0]));
        check("m_parin", 32'(bus.parin), 32'(m_parin));
      end
    end
  end

  // Present a command at a negedge; it is accepted on the next posedge (E0).
  // Fields are scrambled afterwards to show they are not re-sampled.
  task automatic send(input logic load, input logic dir, input logic [CNT_W-1:0] cnt,
                      input logic [WIDTH-1:0] data);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = load;
    bus.cmd_dir   = dir;
    bus.cmd_count = cnt;
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = ~load;
    bus.cmd_dir   = ~dir;
    bus.cmd_count = ~cnt;
    bus.cmd_data  = ~data;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1 && bus.busy === 1'b0) seen = 1'b1;
    end
    check("idle_timeout", 32'(seen), 32'd1);
  endtask

  logic [1:0] seq3 [4];

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_dir   = 1'b0;
    bus.cmd_count = '0;
    bus.cmd_data  = '0;
    seq3[0] = 2'b11;
    seq3[1] = 2'b10;
    seq3[2] = 2'b10;
    seq3[3] = 2'b00;

    // Reset state, before any clock edge.
    #1 clr = 1'b0;
    #2;
    check("rst_sel", 32'(bus.sel), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_parin", 32'(bus.parin), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Load 1011, no shifts.
    send(1'b1, 1'b0, 4'd0, 4'b1011);
    @(negedge clk);
    check("t1_sel_load", 32'(bus.sel), 32'd3);
    check("t1_parin", 32'(bus.parin), 32'hb);
    @(negedge clk);
    check("t1_sel_done", 32'(bus.sel), 32'd0);
    check("t1_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("t1_ready", 32'(bus.cmd_ready), 32'd1);
    check("t1_done_low", 32'(bus.done), 32'd0);
    check("t1_sr", 32'(sr_q), 32'hb);

    // Shift right 3 from 1011.
    send(1'b0, 1'b0, 4'd3, 4'b0110);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_sel_right", 32'(bus.sel), 32'd1);
    end
    @(negedge clk);
    check("t2_sel_done", 32'(bus.sel), 32'd0);
    check("t2_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("t2_ready", 32'(bus.cmd_ready), 32'd1);
    check("t2_sr", 32'(sr_q), 32'b0001);

    // Load 1011, shift left 2.
    send(1'b1, 1'b1, 4'd2, 4'b1011);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_sel_seq", 32'(bus.sel), 32'(seq3[k]));
      check("t3_busy", 32'(bus.busy), 32'd1);
    end
    check("t3_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("t3_busy_low", 32'(bus.busy), 32'd0);
    check("t3_sr", 32'(sr_q), 32'b1100);

    // No-op command.
    send(1'b0, 1'b0, 4'd0, 4'h5);
    @(negedge clk);
    check("t4_ready_low", 32'(bus.cmd_ready), 32'd0);
    check("t4_done", 32'(bus.done), 32'd1);
    check("t4_sel", 32'(bus.sel), 32'd0);
    @(negedge clk);
    check("t4_ready_back", 32'(bus.cmd_ready), 32'd1);
    check("t4_sel_idle", 32'(bus.sel), 32'd0);

    // cmd_valid held high with changing fields during a count=5 command.
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = 1'b0;
    bus.cmd_dir   = 1'b1;
    bus.cmd_count = 4'd5;
    bus.cmd_data  = 4'h3;
    @(posedge clk);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("t5_ready", 32'(bus.cmd_ready), (i == 7) ? 32'd1 : 32'd0);
      bus.cmd_data  = 4'(i);
      bus.cmd_count = 4'd1;
      bus.cmd_dir   = 1'b0;
    end
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    @(negedge clk);
    check("t5_parin2", 32'(bus.parin), 32'd7);
    check("t5_sel2", 32'(bus.sel), 32'd1);
    wait_idle();

    // Long count: 15 shifts, checked by the model.
    send(1'b0, 1'b1, 4'd15, 4'h9);
    wait_idle();
    @(negedge clk);

    // Asynchronous reset after the 2nd of 5 shifts.
    send(1'b0, 1'b0, 4'd5, 4'ha);
    @(negedge clk);
    check("t6_sel_shift", 32'(bus.sel), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3 clr = 1'b0;
    #1;
    check("t6_sel_rst", 32'(bus.sel), 32'd0);
    check("t6_busy_rst", 32'(bus.busy), 32'd0);
    check("t6_parin_rst", 32'(bus.parin), 32'd0);
    check("t6_done_rst", 32'(bus.done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    check("t6_ready_after", 32'(bus.cmd_ready), 32'd1);
    check("t6_no_done", 32'(bus.done), 32'd0);
    @(negedge clk);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
